// File: rtl/enq_queue_arbiter_if.sv
// Method-style bundle between two producers, the arbiter and the shared downstream queue.
// Every port uses the EN_/RDY_ enqueue handshake.
interface enq_queue_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  EN_A_enqueue;
    logic [DATA_WIDTH-1:0] A_enqueue_data;
    logic                  RDY_A_enqueue;

    logic                  EN_B_enqueue;
    logic [DATA_WIDTH-1:0] B_enqueue_data;
    logic                  RDY_B_enqueue;

    logic                  EN_Q_enqueue;
    logic [DATA_WIDTH-1:0] Q_enqueue_data;
    logic                  Q_src;
    logic                  RDY_Q_enqueue;

    // The arbiter side of the bundle.
    modport slave (
        input  EN_A_enqueue, A_enqueue_data,
        output RDY_A_enqueue,
        input  EN_B_enqueue, B_enqueue_data,
        output RDY_B_enqueue,
        output EN_Q_enqueue, Q_enqueue_data, Q_src,
        input  RDY_Q_enqueue
    );

    // The producers and downstream queue.
    modport master (
        output EN_A_enqueue, A_enqueue_data,
        input  RDY_A_enqueue,
        output EN_B_enqueue, B_enqueue_data,
        input  RDY_B_enqueue,
        input  EN_Q_enqueue, Q_enqueue_data, Q_src,
        output RDY_Q_enqueue
    );
endinterface

// File: rtl/enq_queue_arbiter.sv
// Weighted round-robin arbiter sharing one downstream enqueue port between requesters A and B.
// Each side has a 2-entry input FIFO, and a single registered output slot feeds the queue.
module enq_queue_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int WEIGHT_A   = 1,
    parameter int WEIGHT_B   = 1
) (
    input  logic               CLK,
    input  logic               RST,
    enq_queue_arbiter_if.slave bus
);
    typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_e;

    localparam logic [7:0] WeightA = 8'(WEIGHT_A);
    localparam logic [7:0] WeightB = 8'(WEIGHT_B);

    logic [DATA_WIDTH-1:0] memA_q [2];
    logic [DATA_WIDTH-1:0] memB_q [2];
    logic                  rdPtrA_q, rdPtrA_d, wrPtrA_q, wrPtrA_d;
    logic                  rdPtrB_q, rdPtrB_d, wrPtrB_q, wrPtrB_d;
    logic [1:0]            cntA_q, cntA_d, cntB_q, cntB_d;

    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    side_e                 outSrc_q, outSrc_d;

    side_e                 cur_q, cur_d;
    logic [7:0]            run_q, run_d;

    logic                  pushA, pushB, popA, popB;
    logic                  outFree, move;
    side_e                 winner;
    logic [7:0]            curWeight;

    // Ready depends only on state and reset, so no EN input can reach any RDY output.
    assign bus.RDY_A_enqueue  = !RST && (cntA_q != 2'd2);
    assign bus.RDY_B_enqueue  = !RST && (cntB_q != 2'd2);
    assign bus.EN_Q_enqueue   = !RST && outValid_q && bus.RDY_Q_enqueue;
    assign bus.Q_enqueue_data = RST ? '0 : outData_q;
    assign bus.Q_src          = !RST && (outSrc_q == SIDE_B);

    assign pushA = bus.EN_A_enqueue && bus.RDY_A_enqueue;
    assign pushB = bus.EN_B_enqueue && bus.RDY_B_enqueue;

    always_comb begin
        outFree   = !outValid_q || bus.RDY_Q_enqueue;
        move      = outFree && ((cntA_q != 2'd0) || (cntB_q != 2'd0));
        curWeight = (cur_q == SIDE_A) ? WeightA : WeightB;

        // Work-conserving: the owner wins when it has data, otherwise the other side does.
        if (cur_q == SIDE_A) begin
            winner = (cntA_q != 2'd0) ? SIDE_A : SIDE_B;
        end else begin
            winner = (cntB_q != 2'd0) ? SIDE_B : SIDE_A;
        end

        popA = move && (winner == SIDE_A);
        popB = move && (winner == SIDE_B);

        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        cur_d      = cur_q;
        run_d      = run_q;

        if (move) begin
            outValid_d = 1'b1;
            outSrc_d   = winner;
            outData_d  = (winner == SIDE_A) ? memA_q[rdPtrA_q] : memB_q[rdPtrB_q];
            // Only grants to the owner count toward its weight; borrowed grants leave priority alone.
            if (winner == cur_q) begin
                if (run_q + 8'd1 == curWeight) begin
                    cur_d = (cur_q == SIDE_A) ? SIDE_B : SIDE_A;
                    run_d = 8'd0;
                end else begin
                    run_d = run_q + 8'd1;
                end
            end
        end else if (outFree) begin
            outValid_d = 1'b0;
        end

        cntA_d   = cntA_q + 2'(pushA) - 2'(popA);
        cntB_d   = cntB_q + 2'(pushB) - 2'(popB);
        rdPtrA_d = rdPtrA_q ^ popA;
        wrPtrA_d = wrPtrA_q ^ pushA;
        rdPtrB_d = rdPtrB_q ^ popB;
        wrPtrB_d = wrPtrB_q ^ pushB;
    end

    // Buffer storage needs no reset; the counts alone decide what is valid.
    always_ff @(posedge CLK) begin
        if (pushA) memA_q[wrPtrA_q] <= bus.A_enqueue_data;
        if (pushB) memB_q[wrPtrB_q] <= bus.B_enqueue_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cntA_q     <= 2'd0;
            cntB_q     <= 2'd0;
            rdPtrA_q   <= 1'b0;
            wrPtrA_q   <= 1'b0;
            rdPtrB_q   <= 1'b0;
            wrPtrB_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= SIDE_A;
            cur_q      <= SIDE_A;
            run_q      <= 8'd0;
        end else begin
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
            rdPtrA_q   <= rdPtrA_d;
            wrPtrA_q   <= wrPtrA_d;
            rdPtrB_q   <= rdPtrB_d;
            wrPtrB_q   <= wrPtrB_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
            cur_q      <= cur_d;
            run_q      <= run_d;
        end
    end
endmodule

// File: tb/tb_enq_queue_arbiter.sv
// Directed bench for enq_queue_arbiter (WEIGHT_A=3, WEIGHT_B=1) with a per-side scoreboard
// that holds accepted words until they appear on the downstream port.
module tb_enq_queue_arbiter;
    localparam int DW = 32;

    logic CLK;
    logic RST;

    enq_queue_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    enq_queue_arbiter #(
        .DATA_WIDTH(DW),
        .WEIGHT_A  (3),
        .WEIGHT_B  (1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int assertCount = 0;
    int failCount   = 0;

    logic [DW-1:0] expA[$];
    logic [DW-1:0] expB[$];

    logic          obsEnQ, obsSrc, obsRdyA, obsRdyB;
    logic [DW-1:0] obsData;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, samples outputs mid-cycle, then updates the scoreboard.
    task automatic applyStimulus(input logic rst, input logic enA, input logic [DW-1:0] dA,
                                 input logic enB, input logic [DW-1:0] dB, input logic rdyQ);
        RST                = rst;
        bus.EN_A_enqueue   = enA;
        bus.A_enqueue_data = dA;
        bus.EN_B_enqueue   = enB;
        bus.B_enqueue_data = dB;
        bus.RDY_Q_enqueue  = rdyQ;
        @(negedge CLK);
        obsEnQ  = bus.EN_Q_enqueue;
        obsData = bus.Q_enqueue_data;
        obsSrc  = bus.Q_src;
        obsRdyA = bus.RDY_A_enqueue;
        obsRdyB = bus.RDY_B_enqueue;
        if (rst) begin
            expA.delete();
            expB.delete();
        end else begin
            if (obsEnQ) begin
                if (obsSrc) begin
                    checkOutput("sb_b_pending", DW'(expB.size() != 0), 1);
                    if (expB.size() != 0) checkOutput("sb_b_data", obsData, expB.pop_front());
                end else begin
                    checkOutput("sb_a_pending", DW'(expA.size() != 0), 1);
                    if (expA.size() != 0) checkOutput("sb_a_data", obsData, expA.pop_front());
                end
            end
            if (enA && obsRdyA) expA.push_back(dA);
            if (enB && obsRdyB) expB.push_back(dB);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST                = 1'b1;
        bus.EN_A_enqueue   = 1'b0;
        bus.A_enqueue_data = '0;
        bus.EN_B_enqueue   = 1'b0;
        bus.B_enqueue_data = '0;
        bus.RDY_Q_enqueue  = 1'b1;
        @(posedge CLK);
        #1;

        // Reset held three cycles with enables toggling; every output stays low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i[0], 32'hDEAD_0000 + DW'(i), !i[0], 32'hBEEF_0000 + DW'(i), 1'b1);
            checkOutput("rst_enq", obsEnQ, 0);
            checkOutput("rst_data", obsData, 0);
            checkOutput("rst_src", obsSrc, 0);
            checkOutput("rst_rdy_a", obsRdyA, 0);
            checkOutput("rst_rdy_b", obsRdyB, 0);
        end

        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("post_rst_rdy_a", obsRdyA, 1);
        checkOutput("post_rst_rdy_b", obsRdyB, 1);
        checkOutput("post_rst_enq", obsEnQ, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("idle_enq", obsEnQ, 0);

        // Single word from A at cycle 5 appears only in cycle 7.
        applyStimulus(1'b0, 1'b1, 32'h0000_1234, 1'b0, '0, 1'b1);
        checkOutput("single_c5_enq", obsEnQ, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("single_c6_enq", obsEnQ, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("single_c7_enq", obsEnQ, 1);
        checkOutput("single_c7_data", obsData, 32'h0000_1234);
        checkOutput("single_c7_src", obsSrc, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("single_c8_enq", obsEnQ, 0);

        // Reset pulse so the arbiter starts the next phases from cur=A, run=0.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("pulse_enq", obsEnQ, 0);

        // Work-conserving: B alone gets four back-to-back grants while A owns priority.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, '0, (i < 4), 32'hB000_0000 + DW'(i), 1'b1);
            checkOutput("wc_enq", obsEnQ, DW'(i >= 2));
            if (i >= 2) checkOutput("wc_src", obsSrc, 1);
        end

        // Saturation: A,A,A,B repeating proves cur and run were left untouched above.
        for (int n = 0; n < 22; n++) begin
            applyStimulus(1'b0, 1'b1, 32'hA000_0000 + DW'(n), 1'b1, 32'hB100_0000 + DW'(n), 1'b1);
            if (n >= 2) begin
                checkOutput("sat_enq", obsEnQ, 1);
                checkOutput("sat_src", obsSrc, DW'(((n - 2) % 4) == 3));
            end
        end

        // Backpressure: output index 20 (an A word) sits in the slot while the FIFOs fill.
        for (int n = 22; n < 28; n++) begin
            applyStimulus(1'b0, 1'b1, 32'hA000_0000 + DW'(n), 1'b1, 32'hB100_0000 + DW'(n), 1'b0);
            checkOutput("bp_enq", obsEnQ, 0);
            checkOutput("bp_src", obsSrc, 0);
            checkOutput("bp_pending", DW'(expA.size() != 0), 1);
            if (expA.size() != 0) checkOutput("bp_hold_data", obsData, expA[0]);
        end
        checkOutput("bp_rdy_a", obsRdyA, 0);
        checkOutput("bp_rdy_b", obsRdyB, 0);

        // Slot plus two full FIFOs: exactly five words drain.
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
            checkOutput("drain_enq", obsEnQ, DW'(j < 5));
        end
        checkOutput("drain_left_a", DW'(expA.size()), 0);
        checkOutput("drain_left_b", DW'(expB.size()), 0);

        // Fill A with the output stalled, then reset mid-burst.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b1, 32'hC000_0000 + DW'(j), 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("mid_full_rdy_a", obsRdyA, 0);
        applyStimulus(1'b1, 1'b1, 32'hC000_00FF, 1'b1, 32'hC000_01FF, 1'b1);
        checkOutput("mid_rst_enq", obsEnQ, 0);
        checkOutput("mid_rst_rdy_a", obsRdyA, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("mid_after_rdy_a", obsRdyA, 1);
        checkOutput("mid_after_enq", obsEnQ, 0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
            checkOutput("mid_discard_enq", obsEnQ, 0);
        end

        // Simultaneous A and B after reset: A owns priority, so A goes first.
        applyStimulus(1'b0, 1'b1, 32'hD000_000A, 1'b1, 32'hD000_000B, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("cur_c1_enq", obsEnQ, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("cur_c2_enq", obsEnQ, 1);
        checkOutput("cur_c2_src", obsSrc, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("cur_c3_enq", obsEnQ, 1);
        checkOutput("cur_c3_src", obsSrc, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("cur_c4_enq", obsEnQ, 0);

        checkOutput("final_left_a", DW'(expA.size()), 0);
        checkOutput("final_left_b", DW'(expB.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/enq_queue_arbiter.md
# enq_queue_arbiter

Weighted round-robin arbiter that shares one downstream queue enqueue port between two requesters, A and B. Each requester has its own enqueue method. Each side has a 2-entry input buffer. A single registered output slot drives the downstream queue's enqueue method. The block sits between two producer subsystems and a shared queue instance such as the YY/AR-style queues. It uses the same EN_/RDY_ method handshake on every port.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width.
- WEIGHT_A, 1, consecutive grants A may take while B is waiting; legal range 1..255.
- WEIGHT_B, 1, same for B; legal range 1..255.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN_A_enqueue  in  1  requester A enqueue strobe; legal only while RDY_A_enqueue=1.
- A_enqueue_data  in  DATA_WIDTH  requester A payload.
- RDY_A_enqueue  out  1  A's input buffer can accept a word.
- EN_B_enqueue, B_enqueue_data, RDY_B_enqueue  as for A.
- EN_Q_enqueue  out  1  enqueue strobe to the downstream queue.
- Q_enqueue_data  out  DATA_WIDTH  payload to the downstream queue.
- Q_src  out  1  source of the current output word: 0=A, 1=B.
- RDY_Q_enqueue  in  1  downstream queue can accept a word.

Clock is CLK. Reset is RST, synchronous, active-high.

## Operation
- Input buffers:
  - fifoA and fifoB are 2-entry FIFOs with counts cntA and cntB (0..2).
  - RDY_A_enqueue = !RST && cntA<2. It depends only on state and RST, never on any EN.
  - Enqueue and dequeue in the same cycle are permitted; the count is unchanged.
- Output slot: registers out_v, out_data and out_src.
  - EN_Q_enqueue = out_v && RDY_Q_enqueue.
  - Q_enqueue_data = out_data and Q_src = out_src at all times. Data is don't-care when out_v=0.
- Move condition: out_free = !out_v || RDY_Q_enqueue. A move happens when out_free and at least one FIFO is non-empty.
- Arbitration state:
  - cur ∈ {A,B} is the side holding priority.
  - run (8-bit) counts grants given to cur since cur last gained priority.
- Winner selection on a move:
  - winner = cur if FIFO[cur] is non-empty; otherwise winner = the other side.
  - The winner's head word moves to the output slot (out_v<=1, out_src<=winner), and the winner's FIFO pops.
- Priority update on a move:
  - If winner==cur and run+1==WEIGHT_cur: cur flips and run<=0.
  - If winner==cur otherwise: run<=run+1.
  - If winner!=cur: cur and run are unchanged. The scheme is work-conserving; an idle owner keeps priority.
- No move and out_free=1: out_v<=0.
- No move and out_free=0: the output slot holds.
- Reset values:
  - All outputs are 0 while RST=1.
  - cntA=cntB=0, out_v=0, cur=A, run=0.
  - EN_* inputs are ignored during reset, and in-flight words are discarded.

## Timing
- Latency: an enqueue accepted in cycle t is visible in its FIFO at t+1. If granted at t+1, EN_Q_enqueue is high in cycle t+2, provided RDY_Q_enqueue=1. Minimum latency is therefore 2 cycles.
- Throughput: one word per cycle to the downstream queue while any FIFO is non-empty and RDY_Q_enqueue=1.
- Per-requester throughput is one word per cycle when it is granted every cycle.
- Backpressure:
  - With RDY_Q_enqueue=0, the output slot holds its word.
  - The FIFOs fill, and RDY_x_enqueue falls in the cycle after the second buffered word is accepted.
- Combinational paths:
  - RDY_Q_enqueue → EN_Q_enqueue only.
  - There is no path from any EN input to any RDY output.
- Reset mid-operation: with RST high at edge t, all state is at reset values from t+1. Outputs are already 0 during the RST-high cycle.

## Test plan
- Reset: hold RST 3 cycles with EN_A/EN_B toggling -> all outputs 0 throughout. After release: RDY_A/RDY_B=1, EN_Q_enqueue=0.
- Single word, WEIGHT_A=WEIGHT_B=1, RDY_Q=1: EN_A with data 0x1234 at cycle 5 -> EN_Q_enqueue=1, Q_enqueue_data=0x1234, Q_src=0 in cycle 7 only.
- Saturation, WEIGHT_A=3, WEIGHT_B=1: both sides enqueue every cycle, RDY_Q=1 -> Q_src sequence A,A,A,B repeating, one word per cycle, no loss. Per-side data order is preserved (incrementing tags checked).
- Work-conserving: cur=A, only B enqueues 4 words back-to-back -> 4 consecutive B outputs on 4 consecutive cycles. cur stays A and run stays 0.
- Backpressure: both sides saturating, then RDY_Q=0 for 6 cycles -> output word held stable. RDY_A and RDY_B go to 0 once cnt=2. After RDY_Q returns, exactly 5 buffered words drain before new ones, with none dropped or duplicated.
- Reset mid-burst: RST pulsed for 1 cycle with cntA=2 and out_v=1 -> next cycle cntA=0, out_v=0, RDY_A=1, cur=A. The discarded words never appear on Q.
